// File: rtl/recv_serial.sv
// recv_serial: 8N1 serial receiver, WAIT_DIV clocks per bit, mid-bit sampling.
// Define RECV_SERIAL_ERR_EN to add the frame_err output; bad stop bits then do not update data_out.
module recv_serial #(
    parameter int WAIT_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy
`ifdef RECV_SERIAL_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam int WCW = $clog2(WAIT_DIV);
    localparam logic [WCW-1:0] HALF_LAST = WCW'(WAIT_DIV / 2 - 1);
    localparam logic [WCW-1:0] BIT_LAST  = WCW'(WAIT_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e           state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             rx_meta_q, rx_s_q, rx_prev_q;
`ifdef RECV_SERIAL_ERR_EN
    logic             frame_err_q, frame_err_d;
`endif

    // Synchronizer and edge-detect flops reset to the idle (high) line level,
    // so reset itself never looks like a start edge.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values, whatever the statement order.
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= data_in;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
`ifdef RECV_SERIAL_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
`ifdef RECV_SERIAL_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q + WCW'(1);
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
`ifdef RECV_SERIAL_ERR_EN
        frame_err_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (rx_prev_q && !rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (wait_cnt_q == HALF_LAST) begin
                    wait_cnt_d = '0;
                    bit_cnt_d  = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_d    = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (wait_cnt_q == BIT_LAST) begin
                    wait_cnt_d = '0;
                    shreg_d    = {rx_s_q, shreg_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (wait_cnt_q == BIT_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = IDLE;
`ifdef RECV_SERIAL_ERR_EN
                    if (rx_s_q) begin
                        valid_d    = 1'b1;
                        data_out_d = shreg_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
`else
                    valid_d    = 1'b1;
                    data_out_d = shreg_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign busy     = (state_q != IDLE);
`ifdef RECV_SERIAL_ERR_EN
    assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_recv_serial.sv
// Directed bench for recv_serial: WAIT_DIV=16 instance for framing/glitch/reset cases,
// WAIT_DIV=868 instance for bit-time skew tolerance.
module tb_recv_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       din_a, din_b;
    logic [7:0] dout_a, dout_b;
    logic       valid_a, valid_b, busy_a, busy_b;
`ifdef RECV_SERIAL_ERR_EN
    logic       ferr_a, ferr_b;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcnt_a = 0, vcnt_b = 0, dbl = 0, ferr_cnt = 0;
    int last_valid_cyc = 0, start_cyc = 0, v0 = 0;
    logic va_prev = 1'b0, vb_prev = 1'b0;

    recv_serial #(.WAIT_DIV(16)) dut_a (
        .clk(clk), .rst(rst), .data_in(din_a), .data_out(dout_a),
        .valid(valid_a), .busy(busy_a)
`ifdef RECV_SERIAL_ERR_EN
        , .frame_err(ferr_a)
`endif
    );

    recv_serial #(.WAIT_DIV(868)) dut_b (
        .clk(clk), .rst(rst), .data_in(din_b), .data_out(dout_b),
        .valid(valid_b), .busy(busy_b)
`ifdef RECV_SERIAL_ERR_EN
        , .frame_err(ferr_b)
`endif
    );

    // Pulse monitor: counts valid pulses and flags any two-cycle-wide pulse.
    always @(negedge clk) begin
        cyc++;
        if (valid_a) begin
            vcnt_a++;
            last_valid_cyc = cyc;
        end
        if (valid_b) vcnt_b++;
        if ((valid_a && va_prev) || (valid_b && vb_prev)) dbl++;
`ifdef RECV_SERIAL_ERR_EN
        if (ferr_a) ferr_cnt++;
`endif
        va_prev = valid_a;
        vb_prev = valid_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one 10-bit frame, per cycles per bit, starting at the next falling clock edge.
    task automatic send(input bit sel, input logic [7:0] b, input bit stop, input int per,
                        input bit chk_busy);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sel) din_b = fr[i];
            else     din_a = fr[i];
            if (i == 0) start_cyc = cyc;
            repeat (per / 2) @(negedge clk);
            if (chk_busy) check("busy_in_frame", 32'(busy_a), 32'd1);
            repeat (per - per / 2 - 1) @(negedge clk);
        end
    endtask

    initial begin
        logic [9:0] fr;
        rst   = 1'b1;
        din_a = 1'b1;
        din_b = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_dout_a",  32'(dout_a),  32'h00);
        check("rst_valid_a", 32'(valid_a), 32'd0);
        check("rst_busy_a",  32'(busy_a),  32'd0);
        check("rst_dout_b",  32'(dout_b),  32'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single well-formed frame
        send(1'b0, 8'hA5, 1'b1, 16, 1'b1);
        repeat (10) @(negedge clk);
        check("a5_count", 32'(vcnt_a), 32'd1);
        check("a5_data",  32'(dout_a), 32'hA5);
        check("a5_latency_window",
              32'((last_valid_cyc - start_cyc >= 152) && (last_valid_cyc - start_cyc <= 158)), 32'd1);
        check("a5_idle_busy", 32'(busy_a), 32'd0);

        // Back-to-back frames, no idle gap
        send(1'b0, 8'h00, 1'b1, 16, 1'b1);
        check("b2b_first_data", 32'(dout_a), 32'h00);
        send(1'b0, 8'hFF, 1'b1, 16, 1'b1);
        repeat (10) @(negedge clk);
        check("b2b_count",       32'(vcnt_a), 32'd3);
        check("b2b_second_data", 32'(dout_a), 32'hFF);

        // Short low glitch on idle line
        @(negedge clk);
        din_a = 1'b0;
        repeat (4) @(negedge clk);
        din_a = 1'b1;
        @(negedge clk);
        check("glitch_busy_high", 32'(busy_a), 32'd1);
        repeat (7) @(negedge clk);
        check("glitch_busy_low", 32'(busy_a), 32'd0);
        repeat (200) @(negedge clk);
        check("glitch_no_valid", 32'(vcnt_a), 32'd3);

        // Bad stop bit, then line held low (break) before returning high
        send(1'b0, 8'h3C, 1'b0, 16, 1'b1);
        repeat (100) @(negedge clk);
        check("break_no_retrigger", 32'(busy_a), 32'd0);
        din_a = 1'b1;
        repeat (20) @(negedge clk);
`ifdef RECV_SERIAL_ERR_EN
        check("badstop_no_valid",  32'(vcnt_a),   32'd3);
        check("badstop_data_kept", 32'(dout_a),   32'hFF);
        check("badstop_ferr",      32'(ferr_cnt), 32'd1);
`else
        check("badstop_valid", 32'(vcnt_a), 32'd4);
        check("badstop_data",  32'(dout_a), 32'h3C);
`endif

        // Reset in the middle of data bit 4
        v0 = vcnt_a;
        fr = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            din_a = fr[i];
            repeat ((i == 5) ? 7 : 15) @(negedge clk);
        end
        check("midframe_busy", 32'(busy_a), 32'd1);
        rst   = 1'b1;
        din_a = 1'b1;
        @(negedge clk);
        check("midrst_dout",  32'(dout_a),  32'h00);
        check("midrst_valid", 32'(valid_a), 32'd0);
        check("midrst_busy",  32'(busy_a),  32'd0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("midrst_no_valid", 32'(vcnt_a), 32'(v0));
        send(1'b0, 8'h5A, 1'b1, 16, 1'b1);
        repeat (10) @(negedge clk);
        check("after_rst_count", 32'(vcnt_a), 32'(v0 + 1));
        check("after_rst_data",  32'(dout_a), 32'h5A);

        // Bit-time skew on the WAIT_DIV=868 instance: +2% then -2%
        send(1'b1, 8'h41, 1'b1, 885, 1'b0);
        repeat (20) @(negedge clk);
        check("slow_count", 32'(vcnt_b), 32'd1);
        check("slow_data",  32'(dout_b), 32'h41);
        send(1'b1, 8'h41, 1'b1, 851, 1'b0);
        repeat (20) @(negedge clk);
        check("fast_count", 32'(vcnt_b), 32'd2);
        check("fast_data",  32'(dout_b), 32'h41);
        check("fast_idle",  32'(busy_b), 32'd0);

        check("no_double_valid", 32'(dbl), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/recv_serial.md
RECV_SERIAL -- requirements
Module: recv_serial

Interface
REQ-001 Parameter: WAIT_DIV, default 868, meaning clock cycles per serial bit (minimum 4).
REQ-002 The block SHALL have one clock and synchronous, active-high reset, with ports as follows:
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 data_in  input  1  asynchronous serial line; idle high.
REQ-006 data_out  output  8  last received byte.
REQ-007 valid  output  1  one-cycle pulse: a new byte is on data_out.
REQ-008 busy  output  1  high while a frame is being received (state not IDLE).
REQ-009 frame_err  output  1  one-cycle pulse: bad stop bit (present only with RECV_SERIAL_ERR_EN).

Function
REQ-010 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each WAIT_DIV cycles; no parity.
REQ-011 data_in SHALL pass through a 2-flop synchronizer (rx_s); all logic SHALL use rx_s only.
REQ-012 The wait counter SHALL be $clog2(WAIT_DIV) bits wide and the bit counter 3 bits wide.
REQ-013 States SHALL be IDLE, START, DATA and STOP.
REQ-014 IDLE: on a falling edge of rx_s (previous 1, current 0), the block SHALL go to START with wait_cnt=0.
REQ-015 START: at wait_cnt==WAIT_DIV/2-1 (integer division), the block SHALL sample rx_s; if 0, go to DATA with wait_cnt=0 and bit_cnt=0; if 1, treat as a glitch and return to IDLE with no output pulse.
REQ-016 DATA: at wait_cnt==WAIT_DIV-1, the block SHALL shift rx_s into the shift register MSB (shreg={rx_s,shreg[7:1]}) and reset wait_cnt to 0; after the bit with bit_cnt==7, go to STOP.
REQ-017 Otherwise, wait_cnt SHALL increment every cycle in START, DATA and STOP.
REQ-018 STOP: at wait_cnt==WAIT_DIV-1, the block SHALL sample rx_s and return to IDLE.
REQ-019 On a good stop bit (1), the block SHALL load data_out<=shreg and pulse valid for exactly one cycle, registered, in the cycle after the stop sample.
REQ-020 data_out SHALL hold its value until the next valid; valid SHALL never be high on two consecutive cycles.
REQ-021 A new start edge SHALL be accepted from IDLE on the cycle after the return from STOP; back-to-back frames SHALL be received with no lost byte.
REQ-022 A line held low (break) SHALL NOT retrigger reception until rx_s has returned high and fallen again.
REQ-023 busy SHALL be combinational from state: high in START, DATA and STOP.

Reset
REQ-024 While rst=1, the block SHALL set: state=IDLE, wait_cnt=0, bit_cnt=0, shreg=0, data_out=0, valid=0, frame_err=0, synchronizer flops and edge-detect register=1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no valid pulse; the first frame after reset SHALL require a fresh falling edge.

Configuration
REQ-026 Macro RECV_SERIAL_ERR_EN defined: frame_err port exists; a stop bit sampled 0 SHALL pulse frame_err for one cycle (same timing as valid), with no valid pulse and data_out unchanged.
REQ-027 Macro RECV_SERIAL_ERR_EN undefined: frame_err port is absent; the stop bit is sampled but ignored, and every frame completing STOP SHALL load data_out and pulse valid.

Verification (WAIT_DIV=16 unless stated)
REQ-028 Scenario: send 0xA5 with correct framing -> exactly one valid pulse ~160 cycles after the start edge; data_out=0xA5; busy high throughout the frame.
REQ-029 Scenario: 0x00 then 0xFF back-to-back, no idle gap -> two valid pulses; data_out=0x00 then 0xFF.
REQ-030 Scenario: 4-cycle low glitch on an idle line -> return to IDLE after the START sample; no valid pulse; busy low again after 8 cycles.
REQ-031 Scenario: send 0x3C with stop bit=0 -> with RECV_SERIAL_ERR_EN: frame_err pulse, no valid, data_out unchanged; without it: valid pulse, data_out=0x3C.
REQ-032 Scenario: assert rst during bit 4 of a frame -> all outputs 0 the next cycle; no valid pulse; next correct frame 0x5A received.
REQ-033 Scenario: WAIT_DIV=868, send 0x41 at 868 cycles/bit with ±2% bit-time skew -> data_out=0x41, one valid pulse.
